// File: rtl/tcni_pkg.sv
// Shared types and constants for the TCNI receive DMA.
package tcni_pkg;

   typedef logic [15:0] flit_t;
   typedef logic [31:0] memword_t;

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, DONE} rx_state_t;

   localparam logic [3:0] WB_FULL = 4'b1111;
   localparam logic [3:0] WB_LOW  = 4'b0011;

endpackage

// File: rtl/tcni_word_packer.sv
// Packs pairs of 16-bit flits into 32-bit memory words. The word and byte
// enables are registered, so a write appears exactly one cycle after the flit
// that completes it. A trailing odd flit becomes a low-half-only write.
module tcni_word_packer
   import tcni_pkg::*;
(
   input  logic        clock_in,
   input  logic        reset_in,
   input  logic        clear_in,
   input  logic        accept_in,
   input  logic        last_in,
   input  logic [15:0] flit_in,
   output logic [31:0] word_out,
   output logic [3:0]  wb_out,
   output logic        wr_out
);

   flit_t    low_q;
   logic     odd_q;
   memword_t word_q;
   logic [3:0] wb_q;

   // Half-word buffer and one-cycle write strobe; wb_q returns to 0 unless a word completes.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         low_q  <= '0;
         odd_q  <= 1'b0;
         word_q <= '0;
         wb_q   <= '0;
      end else begin
         wb_q <= '0;
         if (clear_in) begin
            odd_q <= 1'b0;
         end else if (accept_in) begin
            if (odd_q) begin
               word_q <= {flit_in, low_q};
               wb_q   <= WB_FULL;
               odd_q  <= 1'b0;
            end else if (last_in) begin
               word_q <= {16'h0000, flit_in};
               wb_q   <= WB_LOW;
            end else begin
               low_q <= flit_in;
               odd_q <= 1'b1;
            end
         end
      end
   end

   assign word_out = word_q;
   assign wb_out   = wb_q;
   assign wr_out   = |wb_q;

endmodule

// File: rtl/tcni_rx_dma.sv
// Receive-side DMA: takes one header-prefixed packet of flits from the router
// and writes the payload to local memory as packed 32-bit words.
// Optional build macro TCNI_RX_CHECKSUM_EN adds checksum_out (XOR of payload flits).
module tcni_rx_dma
   import tcni_pkg::*;
#(
   parameter int MAX_FLITS = 1024,
   parameter int FLIT_W    = 16
) (
   input  logic              clock_in,
   input  logic              reset_in,
   input  logic              start_in,
   input  logic [31:0]       base_addr_in,
   input  logic [FLIT_W-1:0] flit_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [31:0]       mem_addr_out,
   output logic [31:0]       mem_data_out,
   output logic [3:0]        mem_wb_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              err_out,
   output logic [15:0]       len_out
`ifdef TCNI_RX_CHECKSUM_EN
   ,
   output logic [15:0]       checksum_out
`endif
);

   localparam logic [15:0] MAX_L = 16'(MAX_FLITS);

   rx_state_t state_q, state_d;
   logic [31:0] addr_q;
   logic [15:0] cnt_q;
   logic        discard_q;
   logic        accept;
   logic        pay_last;
   logic        start_ok;
   logic        wr;

   assign accept   = valid_in & ready_out;
   assign pay_last = (cnt_q == len_out - 16'd1);
   assign start_ok = (state_q == IDLE) & start_in;

   // State register.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state and flow control; start_in only counts in IDLE.
   always_comb begin
      state_d   = state_q;
      ready_out = 1'b0;
      case (state_q)
         IDLE:    if (start_in) state_d = HDR;
         HDR: begin
            ready_out = 1'b1;
            if (valid_in) state_d = (flit_in == '0) ? DONE : PAYLOAD;
         end
         PAYLOAD: begin
            ready_out = 1'b1;
            if (valid_in && pay_last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy_out = (state_q != IDLE);
   assign done_out = (state_q == DONE);

   // Packet bookkeeping: base address, header length, payload index, error/discard.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         addr_q    <= '0;
         len_out   <= '0;
         cnt_q     <= '0;
         discard_q <= 1'b0;
         err_out   <= 1'b0;
      end else begin
         if (start_ok) begin
            addr_q  <= base_addr_in;
            err_out <= 1'b0;
         end else if (wr) begin
            addr_q  <= addr_q + 32'd4;
         end
         if (state_q == HDR && accept) begin
            len_out   <= flit_in;
            cnt_q     <= '0;
            discard_q <= (flit_in > MAX_L);
            err_out   <= (flit_in > MAX_L);
         end else if (state_q == PAYLOAD && accept) begin
            cnt_q <= cnt_q + 16'd1;
         end
      end
   end

   tcni_word_packer u_packer (
      .clock_in  (clock_in),
      .reset_in  (reset_in),
      .clear_in  (start_ok),
      .accept_in ((state_q == PAYLOAD) & accept & ~discard_q),
      .last_in   (pay_last),
      .flit_in   (flit_in),
      .word_out  (mem_data_out),
      .wb_out    (mem_wb_out),
      .wr_out    (wr)
   );

   assign mem_addr_out = addr_q;

`ifdef TCNI_RX_CHECKSUM_EN
   // Running XOR of every payload flit, discarded packets included.
   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in)                         checksum_out <= '0;
      else if (start_ok)                     checksum_out <= '0;
      else if (state_q == PAYLOAD && accept) checksum_out <= checksum_out ^ flit_in;
   end
`endif

endmodule
